// File: rtl/lpif_rxfifo_asym2_half_pack.sv
// rtl/lpif_rxfifo_asym2_half_pack.sv - RX gearbox pairing LPIF half-beats into full words with FWFT FIFO
//
// Pairs consecutive 77-bit half-beats into one 154-bit word.
// The first beat of a pair goes to bits [HALF_W-1:0]; the second goes to [2*HALF_W-1:HALF_W].
// Paired words are buffered in a small first-word-fall-through FIFO.
//
// Optional feature macro: LPIF_ASYM2_MARKER_CHECK_EN
//   When defined, the in_first marker enforces alignment and misalignment sets the sticky align_err flag.
//   When undefined, pairing is purely positional and align_err is tied to 0.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   flush                     synchronous clear of the pairing state and the FIFO (align_err is held)
//   in_data/in_first/in_vld   incoming half-beat, first-of-pair marker, valid
//   in_rdy                    gearbox accepts in_data this cycle
//   rxfifo_downstream_data    head-of-FIFO paired word
//   rxfifo_downstream_vld     head entry valid
//   rxfifo_downstream_rdy     consumer pops the head when vld & rdy
//   fifo_level                occupied entries
//   align_err                 sticky marker misalignment flag

module lpif_rxfifo_asym2_half_pack #(
    parameter int HALF_W     = 77,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic [HALF_W-1:0]             in_data,
    input  logic                          in_first,
    input  logic                          in_vld,
    output logic                          in_rdy,
    output logic [2*HALF_W-1:0]           rxfifo_downstream_data,
    output logic                          rxfifo_downstream_vld,
    input  logic                          rxfifo_downstream_rdy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          align_err
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic {
        ST_LO = 1'b0,
        ST_HI = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [HALF_W-1:0]    lo_q;
    logic [2*HALF_W-1:0]  mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr, rd_ptr;
    logic [LW-1:0]        level;

    logic accept;
    logic lo_load;
    logic push;
    logic pop;
    logic mark_err;

    // in_rdy deliberately looks only at the registered level: a pop in
    // the same cycle does not free a slot for a push until the next cycle.
    assign in_rdy = (state_q == ST_LO) | (level < LW'(FIFO_DEPTH));
    assign accept = in_vld & in_rdy;
    assign pop    = (level != '0) & rxfifo_downstream_rdy;

    always_comb begin
        state_d  = state_q;
        lo_load  = 1'b0;
        push     = 1'b0;
        mark_err = 1'b0;
        if (accept) begin
            case (state_q)
                ST_LO: begin
`ifdef LPIF_ASYM2_MARKER_CHECK_EN
                    // A second half with no preceding first half is dropped.
                    if (!in_first) begin
                        mark_err = 1'b1;
                    end else begin
                        lo_load = 1'b1;
                        state_d = ST_HI;
                    end
`else
                    lo_load = 1'b1;
                    state_d = ST_HI;
`endif
                end
                ST_HI: begin
`ifdef LPIF_ASYM2_MARKER_CHECK_EN
                    // A new first half restarts the pair; the stale low half is replaced.
                    if (in_first) begin
                        lo_load  = 1'b1;
                        mark_err = 1'b1;
                    end else begin
                        push    = 1'b1;
                        state_d = ST_LO;
                    end
`else
                    push    = 1'b1;
                    state_d = ST_LO;
`endif
                end
                default: state_d = ST_LO;
            endcase
        end
    end

`ifndef LPIF_ASYM2_MARKER_CHECK_EN
    logic unused_marker;
    assign unused_marker = in_first | mark_err;
`endif

    // flush clears everything rst clears, except the sticky error flag.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            state_q <= ST_LO;
            lo_q    <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level   <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            if (lo_load) begin
                lo_q <= in_data;
            end
            if (push) begin
                mem[wr_ptr] <= {in_data, lo_q};
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

`ifdef LPIF_ASYM2_MARKER_CHECK_EN
    logic align_err_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            align_err_q <= 1'b0;
        end else if (mark_err && !flush) begin
            align_err_q <= 1'b1;
        end
    end
    assign align_err = align_err_q;
`else
    assign align_err = 1'b0;
`endif

    assign rxfifo_downstream_data = mem[rd_ptr];
    assign rxfifo_downstream_vld  = (level != '0);
    assign fifo_level             = level;

endmodule

// File: tb/tb_lpif_rxfifo_asym2_half_pack.sv
// tb/tb_lpif_rxfifo_asym2_half_pack.sv - self-checking bench for lpif_rxfifo_asym2_half_pack

module tb_lpif_rxfifo_asym2_half_pack;

    localparam int HW = 77;

    logic            clk = 1'b0;
    logic            rst;
    logic            flush;
    logic [HW-1:0]   in_data;
    logic            in_first;
    logic            in_vld;
    logic            in_rdy;
    logic [2*HW-1:0] out_data;
    logic            out_vld;
    logic            out_rdy;
    logic [2:0]      fifo_level;
    logic            align_err;

    int ncmp  = 0;
    int nfail = 0;

    always #5 clk = ~clk;

    lpif_rxfifo_asym2_half_pack #(.HALF_W(HW), .FIFO_DEPTH(4)) dut (
        .clk                    (clk),
        .rst                    (rst),
        .flush                  (flush),
        .in_data                (in_data),
        .in_first               (in_first),
        .in_vld                 (in_vld),
        .in_rdy                 (in_rdy),
        .rxfifo_downstream_data (out_data),
        .rxfifo_downstream_vld  (out_vld),
        .rxfifo_downstream_rdy  (out_rdy),
        .fifo_level             (fifo_level),
        .align_err              (align_err)
    );

    typedef struct {
        logic            rst;
        logic            flush;
        logic            vld;
        logic            first;
        logic [HW-1:0]   d;
        logic            rdy;
        logic            e_rdy;
        logic            e_vld;
        logic [2:0]      e_lvl;
        logic            chk_d;
        logic [2*HW-1:0] e_d;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [2*HW-1:0] w(input logic [HW-1:0] hi, input logic [HW-1:0] lo);
        return {hi, lo};
    endfunction

    task automatic add(input logic r, input logic f, input logic v, input logic fst,
                       input logic [HW-1:0] d, input logic rd, input logic er, input logic ev,
                       input logic [2:0] el, input logic cd, input logic [2*HW-1:0] ed);
        vec_t x;
        x.rst = r; x.flush = f; x.vld = v; x.first = fst; x.d = d; x.rdy = rd;
        x.e_rdy = er; x.e_vld = ev; x.e_lvl = el; x.chk_d = cd; x.e_d = ed;
        vecs.push_back(x);
    endtask

    task automatic chk(input string name, input logic [2*HW-1:0] act, input logic [2*HW-1:0] exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; flush = 1'b0; in_vld = 1'b0; in_first = 1'b0; in_data = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Offer one half-beat until accepted, bounded to 20 cycles.
    task automatic send(input logic [HW-1:0] d, input logic fst);
        logic acc;
        acc = 1'b0;
        in_vld = 1'b1; in_data = d; in_first = fst;
        for (int c = 0; c < 20 && !acc; c++) begin
            acc = in_rdy;
            tick();
        end
        in_vld = 1'b0;
        if (!acc) begin
            ncmp++;
            nfail++;
            $display("FAIL send_timeout: got no accept expected accept of %h", d);
        end
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_vld = 1'b0; in_first = 1'b0; in_data = '0; out_rdy = 1'b0;

        // rst flush vld first data rdy | e_rdy e_vld e_lvl chk_d e_d
        add(1,0,0,0,77'd0, 0, 1,0,0,1, '0);            // T1 reset, 2 cycles
        add(1,0,0,0,77'd0, 0, 1,0,0,1, '0);
        add(0,0,1,1,77'd1, 1, 1,0,0,1, '0);            // T2 A
        add(0,0,1,0,77'd2, 1, 1,1,1,1, w(77'd2,77'd1)); // T2 B -> {B,A} next cycle
        add(0,0,0,0,77'd0, 1, 1,0,0,0, '0);            // popped
        add(0,0,1,1,77'd3, 0, 1,0,0,0, '0);
        add(0,0,1,0,77'd4, 0, 1,1,1,1, w(77'd4,77'd3));
        add(0,0,0,0,77'd0, 0, 1,1,1,1, w(77'd4,77'd3)); // held while not ready
        add(0,0,0,0,77'd0, 1, 1,0,0,0, '0);            // pop
        add(0,0,0,0,77'd0, 1, 1,0,0,0, '0);            // pop when empty ignored
        add(0,0,1,1,77'd5, 0, 1,0,0,0, '0);
        add(0,0,1,0,77'd6, 0, 1,1,1,1, w(77'd6,77'd5));
        add(0,0,1,1,77'd7, 1, 1,0,0,0, '0);            // capture lo + pop
        add(0,0,1,0,77'd8, 0, 1,1,1,1, w(77'd8,77'd7));
        add(0,0,1,1,77'd9, 1, 1,0,0,0, '0);
        add(0,0,1,0,77'd10,0, 1,1,1,1, w(77'd10,77'd9));
        add(0,0,1,1,77'd11,0, 1,1,1,1, w(77'd10,77'd9));
        add(0,0,1,0,77'd12,1, 1,1,1,1, w(77'd12,77'd11)); // push + pop same cycle
        add(0,0,0,0,77'd0, 1, 1,0,0,0, '0);
        add(0,0,1,1,77'd13,1, 1,0,0,0, '0);            // pending half
        add(1,0,0,0,77'd0, 1, 1,0,0,1, '0);            // reset mid-pair loses it
        add(0,0,1,1,77'd14,0, 1,0,0,0, '0);
        add(0,0,1,0,77'd15,0, 1,1,1,1, w(77'd15,77'd14));
        add(0,0,0,0,77'd0, 1, 1,0,0,0, '0);

        for (int i = 0; i < vecs.size(); i++) begin
            rst = vecs[i].rst; flush = vecs[i].flush; in_vld = vecs[i].vld;
            in_first = vecs[i].first; in_data = vecs[i].d; out_rdy = vecs[i].rdy;
            tick();
            chk($sformatf("vec%0d_in_rdy", i), {153'd0, in_rdy}, {153'd0, vecs[i].e_rdy});
            chk($sformatf("vec%0d_vld", i),    {153'd0, out_vld}, {153'd0, vecs[i].e_vld});
            chk($sformatf("vec%0d_level", i),  {151'd0, fifo_level}, {151'd0, vecs[i].e_lvl});
            if (vecs[i].chk_d)
                chk($sformatf("vec%0d_data", i), out_data, vecs[i].e_d);
            chk($sformatf("vec%0d_align_err", i), {153'd0, align_err}, 154'd0);
        end

        // T3 + T4: backpressure fill, in_rdy low in HI when full, simultaneous pop/offer
        out_rdy = 1'b0;
        do_reset();
        for (int i = 0; i < 9; i++) begin
            send(77'd100 + 77'(i), (i % 2) == 0);
            if (i == 7) chk("t3_level_after_8", {151'd0, fifo_level}, 154'd4);
        end
        chk("t3_in_rdy_full_hi", {153'd0, in_rdy}, 154'd0);
        in_vld = 1'b1; in_data = 77'd109; in_first = 1'b0; out_rdy = 1'b1;
        chk("t4_head_before_pop", out_data, w(77'd101, 77'd100));
        tick();
        chk("t4_level_after_pop", {151'd0, fifo_level}, 154'd3);
        chk("t4_in_rdy_after_pop", {153'd0, in_rdy}, 154'd1);
        out_rdy = 1'b0;
        tick();
        in_vld = 1'b0;
        chk("t4_level_refilled", {151'd0, fifo_level}, 154'd4);
        out_rdy = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("t3_drain%0d_vld", k), {153'd0, out_vld}, 154'd1);
            chk($sformatf("t3_drain%0d_data", k), out_data,
                w(77'd103 + 77'(2*k), 77'd102 + 77'(2*k)));
            tick();
        end
        chk("t3_level_drained", {151'd0, fifo_level}, 154'd0);
        chk("t3_vld_drained", {153'd0, out_vld}, 154'd0);
        out_rdy = 1'b0;

        // T5: flush mid-pair, plus flush beats a same-cycle push
        do_reset();
        send(77'd200, 1'b1);
        send(77'd201, 1'b0);
        send(77'd202, 1'b1);
        flush = 1'b1; in_vld = 1'b1; in_data = 77'd203; in_first = 1'b0; out_rdy = 1'b1;
        tick();
        flush = 1'b0; in_vld = 1'b0; out_rdy = 1'b0;
        chk("t5_level_flush", {151'd0, fifo_level}, 154'd0);
        chk("t5_vld_flush", {153'd0, out_vld}, 154'd0);
        chk("t5_data_flush", out_data, '0);
        send(77'd204, 1'b1);
        send(77'd205, 1'b0);
        chk("t5_level_after", {151'd0, fifo_level}, 154'd1);
        chk("t5_pair_after_flush", out_data, w(77'd205, 77'd204));

`ifdef LPIF_ASYM2_MARKER_CHECK_EN
        // T6: first=1,1,0 -> first beat dropped, error raised
        do_reset();
        chk("t6_err_reset", {153'd0, align_err}, 154'd0);
        send(77'd300, 1'b1);
        send(77'd301, 1'b1);
        send(77'd302, 1'b0);
        chk("t6_align_err", {153'd0, align_err}, 154'd1);
        chk("t6_word", out_data, w(77'd302, 77'd301));
        out_rdy = 1'b1;
        tick();
        out_rdy = 1'b0;
        send(77'd303, 1'b0);  // second half in LO: dropped
        chk("t6_drop_level", {151'd0, fifo_level}, 154'd0);
        send(77'd304, 1'b1);
        send(77'd305, 1'b0);
        chk("t6_word2", out_data, w(77'd305, 77'd304));
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("t6_err_held_flush", {153'd0, align_err}, 154'd1);
        do_reset();
        chk("t6_err_cleared_rst", {153'd0, align_err}, 154'd0);
`else
        // Without marker checking, in_first is ignored
        do_reset();
        send(77'd400, 1'b0);
        send(77'd401, 1'b1);
        chk("pos_word", out_data, w(77'd401, 77'd400));
        chk("pos_align_err", {153'd0, align_err}, 154'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
